cfg_bitstream_loader: RTL and testbench
=======================================

Name: cfg_bitstream_loader

Overview:
- Transmit end of the configuration-memory load interface.
- Accepts parallel frame words over a valid/ready handshake and serializes each word LSB-first onto MASTER_DIN, qualified by MASTER_EN.
- Pulses CH_ADDR between blocks so the memory controller advances to the next block, and raises PROG_DONE after the last block.
- Sits between the configuration source (ROM/host FIFO) and the memory controller that drives BLOCK_SEL/BLOCK_DIN.

Parameters:
- FRAME_BITS, 18, bits per block frame.
- NUM_BLOCKS, 77, frames per complete configuration.
- CNT_W, 7, width of block counter; must satisfy 2^CNT_W >= NUM_BLOCKS.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  begin a configuration pass; sampled only in IDLE or DONE.
- WORD_DATA  in  FRAME_BITS  frame word; bit 0 is shifted first.
- WORD_VALID  in  1  WORD_DATA valid.
- WORD_READY  out  1  loader can accept a word; transfer occurs when WORD_VALID&WORD_READY.
- MASTER_DIN  out  1  serial config data.
- MASTER_EN  out  1  qualifies MASTER_DIN; one bit is transferred per cycle while high.
- CH_ADDR  out  1  one-cycle pulse that advances the receiver to the next block.
- PROG_DONE  out  1  configuration complete; level output.
- BUSY  out  1  high in every state except IDLE and DONE.
- BLOCK_CNT  out  CNT_W  index of the block currently being loaded (0-based).

Behaviour:
- Reset, while RST_N=0 at the clock edge:
  - state=IDLE.
  - All outputs 0: MASTER_DIN, MASTER_EN, CH_ADDR, PROG_DONE, WORD_READY, BUSY, BLOCK_CNT.
  - Shift register and bit counter cleared.
  - Reset mid-pass aborts the pass immediately and emits no CH_ADDR or PROG_DONE.
- All outputs are registered.
- States:
  - IDLE: START=1 -> FETCH, BLOCK_CNT=0.
  - FETCH: WORD_READY=1, MASTER_EN=0, MASTER_DIN=0. On handshake, load the shift register and bit counter=0, then -> SHIFT. Without WORD_VALID, remain in FETCH indefinitely; no bits are emitted.
  - SHIFT: MASTER_EN=1, MASTER_DIN=shift_reg[0]; shift right each cycle for exactly FRAME_BITS cycles. After the last bit:
    - if BLOCK_CNT==NUM_BLOCKS-1 -> DONE;
    - otherwise -> ADVANCE.
  - ADVANCE: exactly one cycle with CH_ADDR=1, MASTER_EN=0, MASTER_DIN=0. BLOCK_CNT increments, then -> FETCH.
  - DONE: PROG_DONE=1, held; WORD_READY=0. START=1 -> PROG_DONE=0, BLOCK_CNT=0, -> FETCH.
- Latency:
  - Handshake at edge t: bit i appears on MASTER_DIN during cycle t+1+i (i = 0..FRAME_BITS-1).
  - CH_ADDR is high during cycle t+FRAME_BITS+1.
  - WORD_READY is high again from cycle t+FRAME_BITS+2.
  - Last block: PROG_DONE rises at t+FRAME_BITS+1, and no CH_ADDR is issued.
- Minimum cost is FRAME_BITS+2 cycles per non-final block.
- CH_ADDR is never asserted together with MASTER_EN or PROG_DONE.
- START is ignored while BUSY=1; WORD_VALID is ignored outside FETCH.
- START and RST_N=0 in the same cycle: reset wins.
- NUM_BLOCKS=1: the single frame goes directly to DONE, with no CH_ADDR.
- BLOCK_CNT never exceeds NUM_BLOCKS-1; there is no wrap-around.

Test Plan:
1. Reset: hold RST_N=0 for 3 cycles with START=1 and WORD_VALID=1 -> every output is 0 and state is IDLE; after release, START starts a pass one cycle later (WORD_READY=1).
2. Single frame, NUM_BLOCKS=1, WORD_DATA=18'b101001010010110100 presented at the first WORD_READY:
   - MASTER_DIN sequence 0,0,1,0,1,1,0,1,0,0,1,0,1,0,0,1,0,1 over 18 cycles with MASTER_EN=1;
   - then PROG_DONE=1 and CH_ADDR never pulsed.
3. Three blocks, NUM_BLOCKS=3, WORD_VALID tied high, same word:
   - CH_ADDR pulses exactly twice, each for 1 cycle, 20 cycles apart;
   - BLOCK_CNT steps 0->1->2;
   - PROG_DONE rises 19 cycles after the third handshake;
   - 54 total cycles with MASTER_EN=1.
4. Stall: NUM_BLOCKS=3, WORD_VALID=0 for 5 cycles before block 1 -> WORD_READY stays 1, MASTER_EN stays 0, no extra CH_ADDR, and the serial stream resumes correctly after the stall.
5. Restart from DONE: START=1 -> PROG_DONE falls the next cycle, BLOCK_CNT=0, WORD_READY=1; a second full pass is bit-identical to the first. START pulsed mid-SHIFT has no effect.
6. Reset mid-pass: RST_N=0 at bit 9 of block 1 -> all outputs are 0 on the next cycle, with no CH_ADDR or PROG_DONE; a fresh START reloads from block 0.

Source files
------------

// File: rtl/cfg_bitstream_loader_if.sv
// Frame-word handshake bundle for the configuration bitstream loader.
// Ports: WORD_DATA/WORD_VALID from the source, WORD_READY from the loader.
interface cfg_bitstream_loader_if #(
  parameter int FRAME_BITS = 18
);
  logic [FRAME_BITS-1:0] WORD_DATA;
  logic                  WORD_VALID;
  logic                  WORD_READY;

  modport master (
    output WORD_DATA,
    output WORD_VALID,
    input  WORD_READY
  );

  modport slave (
    input  WORD_DATA,
    input  WORD_VALID,
    output WORD_READY
  );
endinterface

// File: rtl/cfg_bitstream_loader.sv
// Serializes frame words LSB-first onto MASTER_DIN/MASTER_EN, pulses CH_ADDR.
// Ports: CLK, RST_N, START, word (slave), MASTER_*, CH_ADDR, PROG_DONE, BUSY, BLOCK_CNT.
module cfg_bitstream_loader #(
  parameter int FRAME_BITS = 18,
  parameter int NUM_BLOCKS = 77,
  parameter int CNT_W      = 7
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  cfg_bitstream_loader_if.slave word,
  output logic             MASTER_DIN,
  output logic             MASTER_EN,
  output logic             CH_ADDR,
  output logic             PROG_DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] BLOCK_CNT
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT =
    BIT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_BLK =
    CNT_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    ADVANCE,
    DONE
  } state_t;

  state_t state, state_n;

  logic [FRAME_BITS-1:0] shift_q, shift_n;
  logic [BIT_W-1:0]      bit_q, bit_n;
  logic [CNT_W-1:0]      blk_n;
  logic                  rdy_q;
  logic                  din_n, en_n, ch_n;
  logic                  done_n, rdy_n, busy_n;

  assign word.WORD_READY = rdy_q;

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    bit_n   = bit_q;
    blk_n   = BLOCK_CNT;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_n = FETCH;
          blk_n   = '0;
        end
      end
      FETCH: begin
        if (word.WORD_VALID && rdy_q) begin
          shift_n = word.WORD_DATA;
          bit_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        shift_n = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
          if (BLOCK_CNT == LAST_BLK)
            state_n = DONE;
          else
            state_n = ADVANCE;
        end else begin
          bit_n = bit_q + BIT_W'(1);
        end
      end
      ADVANCE: begin
        blk_n   = BLOCK_CNT + CNT_W'(1);
        state_n = FETCH;
      end
      DONE: begin
        if (START) begin
          state_n = FETCH;
          blk_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state;
    // the serial bit is the LSB of the next shift-register value.
    din_n  = (state_n == SHIFT) && shift_n[0];
    en_n   = (state_n == SHIFT);
    ch_n   = (state_n == ADVANCE);
    done_n = (state_n == DONE);
    rdy_n  = (state_n == FETCH);
    busy_n = (state_n == FETCH) ||
             (state_n == SHIFT) ||
             (state_n == ADVANCE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      BLOCK_CNT  <= '0;
      rdy_q      <= 1'b0;
      MASTER_DIN <= 1'b0;
      MASTER_EN  <= 1'b0;
      CH_ADDR    <= 1'b0;
      PROG_DONE  <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_n;
      shift_q    <= shift_n;
      bit_q      <= bit_n;
      BLOCK_CNT  <= blk_n;
      rdy_q      <= rdy_n;
      MASTER_DIN <= din_n;
      MASTER_EN  <= en_n;
      CH_ADDR    <= ch_n;
      PROG_DONE  <= done_n;
      BUSY       <= busy_n;
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Randomized self-checking bench for cfg_bitstream_loader.
// Drives a 1-block and a 3-block instance and checks against a word-level model.
module tb_cfg_bitstream_loader;

  localparam int FB = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start3;
  logic din1, en1, ch1, done1, busy1;
  logic din3, en3, ch3, done3, busy3;
  logic [6:0] bc1, bc3;

  cfg_bitstream_loader_if #(.FRAME_BITS(FB)) if1 ();
  cfg_bitstream_loader_if #(.FRAME_BITS(FB)) if3 ();

  cfg_bitstream_loader #(
    .FRAME_BITS(FB), .NUM_BLOCKS(1), .CNT_W(7)
  ) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .word(if1),
    .MASTER_DIN(din1), .MASTER_EN(en1), .CH_ADDR(ch1),
    .PROG_DONE(done1), .BUSY(busy1), .BLOCK_CNT(bc1)
  );

  cfg_bitstream_loader #(
    .FRAME_BITS(FB), .NUM_BLOCKS(3), .CNT_W(7)
  ) dut3 (
    .CLK(clk), .RST_N(rst_n), .START(start3), .word(if3),
    .MASTER_DIN(din3), .MASTER_EN(en3), .CH_ADDR(ch3),
    .PROG_DONE(done3), .BUSY(busy3), .BLOCK_CNT(bc3)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FB-1:0] spec_w = 18'b101001010010110100;
  bit spec_seq [FB] = '{0,0,1,0,1,1,0,1,0,0,1,0,1,0,0,1,0,1};

  logic [FB-1:0] pw [3];
  int hs [3];
  int ch_t [$];
  bit bits [$];
  int bcs [$];
  int en_n, coll, done_t, stall_rdy_bad, stall_en;
  int r_done0, r_bc0, r_rdy0;
  bit timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    if1.WORD_VALID = 1'b0;
    if3.WORD_VALID = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Runs one 3-block pass on dut3 and records what was observed.
  task automatic record_pass(input int stall_blk, input int stall_len,
                             input int poke_at);
    int k, st, n;
    bit fin;
    k = 0; st = 0; n = 0; fin = 0;
    bits.delete(); ch_t.delete(); bcs.delete();
    en_n = 0; coll = 0; done_t = -1;
    stall_rdy_bad = 0; stall_en = 0; timeout = 0;
    foreach (hs[i]) hs[i] = -1;
    start3 = 1'b1;
    if3.WORD_VALID = 1'b0;
    step();
    start3 = 1'b0;
    r_done0 = int'(done3);
    r_bc0 = int'(bc3);
    r_rdy0 = int'(if3.WORD_READY);
    bcs.push_back(int'(bc3));
    while (!fin) begin
      if (en3) begin bits.push_back(din3); en_n++; end
      if (ch3) ch_t.push_back(cyc);
      if (ch3 && (en3 || done3)) coll++;
      if (int'(bc3) != bcs[$]) bcs.push_back(int'(bc3));
      if (done3) begin
        done_t = cyc;
        fin = 1;
      end else if (n > 400) begin
        timeout = 1;
        fin = 1;
      end else begin
        start3 = (n == poke_at);
        if (k == stall_blk && st < stall_len &&
            (st > 0 || if3.WORD_READY)) begin
          st++;
          if3.WORD_VALID = 1'b0;
          if3.WORD_DATA = FB'($urandom);
          if (!if3.WORD_READY) stall_rdy_bad++;
          if (en3) stall_en++;
        end else if (if3.WORD_READY && k < 3) begin
          if3.WORD_VALID = 1'b1;
          if3.WORD_DATA = pw[k];
          hs[k] = cyc + 1;
          k++;
        end else begin
          if3.WORD_VALID = 1'($urandom);
          if3.WORD_DATA = FB'($urandom);
        end
        n++;
        step();
      end
    end
    start3 = 1'b0;
    if3.WORD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b1;
    start3 = 1'b1;
    if1.WORD_VALID = 1'b1;
    if3.WORD_VALID = 1'b1;
    if1.WORD_DATA = FB'($urandom);
    if3.WORD_DATA = FB'($urandom);
    repeat (3) step();
    total++;
    if ({din1, en1, ch1, done1, busy1, if1.WORD_READY, bc1} !== '0) begin
      bad++;
      $display("FAIL reset_out1 got=%b want=0",
               {din1, en1, ch1, done1, busy1, if1.WORD_READY, bc1});
    end
    total++;
    if ({din3, en3, ch3, done3, busy3, if3.WORD_READY, bc3} !== '0) begin
      bad++;
      $display("FAIL reset_out3 got=%b want=0",
               {din3, en3, ch3, done3, busy3, if3.WORD_READY, bc3});
    end
    rst_n = 1'b1;
    if1.WORD_VALID = 1'b0;
    if3.WORD_VALID = 1'b0;
    step();
    total++;
    if (if3.WORD_READY !== 1'b1 || busy3 !== 1'b1) begin
      bad++;
      $display("FAIL reset_start3 got rdy=%b busy=%b want 1 1",
               if3.WORD_READY, busy3);
    end
    total++;
    if (if1.WORD_READY !== 1'b1 || bc1 !== 7'd0) begin
      bad++;
      $display("FAIL reset_start1 got rdy=%b bc=%0d want 1 0",
               if1.WORD_READY, bc1);
    end
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic test_single();
    int w, chs;
    do_reset();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    w = 0;
    while (!if1.WORD_READY && w < 10) begin step(); w++; end
    total++;
    if (if1.WORD_READY !== 1'b1) begin
      bad++;
      $display("FAIL single_ready got=%b want=1", if1.WORD_READY);
    end
    if1.WORD_DATA = spec_w;
    if1.WORD_VALID = 1'b1;
    step();
    if1.WORD_VALID = 1'b0;
    chs = 0;
    for (int i = 0; i < FB; i++) begin
      total++;
      if (en1 !== 1'b1 || din1 !== spec_seq[i]) begin
        bad++;
        $display("FAIL single_bit%0d got en=%b din=%b want en=1 din=%b",
                 i, en1, din1, spec_seq[i]);
      end
      chs += int'(ch1);
      if1.WORD_VALID = 1'($urandom);
      if1.WORD_DATA = FB'($urandom);
      step();
    end
    total++;
    if (done1 !== 1'b1 || en1 !== 1'b0) begin
      bad++;
      $display("FAIL single_done got done=%b en=%b want 1 0", done1, en1);
    end
    for (int i = 0; i < 6; i++) begin
      chs += int'(ch1);
      if1.WORD_VALID = 1'b1;
      step();
    end
    if1.WORD_VALID = 1'b0;
    total++;
    if (done1 !== 1'b1 || if1.WORD_READY !== 1'b0 || chs != 0) begin
      bad++;
      $display("FAIL single_hold got done=%b rdy=%b ch=%0d want 1 0 0",
               done1, if1.WORD_READY, chs);
    end
  endtask

  task automatic test_three_blocks();
    int c0, c1, nerr;
    do_reset();
    for (int b = 0; b < 3; b++) pw[b] = spec_w;
    record_pass(-1, 0, -1);
    c0 = ch_t.size() > 0 ? ch_t[0] : -1;
    c1 = ch_t.size() > 1 ? ch_t[1] : -1;
    total++;
    if (timeout || ch_t.size() != 2) begin
      bad++;
      $display("FAIL three_ch_count got=%0d timeout=%0d want 2 0",
               ch_t.size(), timeout);
    end
    total++;
    if (c0 != hs[0] + FB || c1 != hs[1] + FB || c1 - c0 != FB + 2) begin
      bad++;
      $display("FAIL three_ch_time got %0d,%0d want %0d,%0d gap %0d",
               c0, c1, hs[0] + FB, hs[1] + FB, FB + 2);
    end
    total++;
    if (done_t != hs[2] + FB) begin
      bad++;
      $display("FAIL three_done_time got=%0d want=%0d", done_t, hs[2] + FB);
    end
    total++;
    if (en_n != 3 * FB || coll != 0) begin
      bad++;
      $display("FAIL three_en got en=%0d coll=%0d want %0d 0",
               en_n, coll, 3 * FB);
    end
    total++;
    if (bcs.size() != 3 || bcs[0] != 0 || bcs[1] != 1 || bcs[2] != 2) begin
      bad++;
      $display("FAIL three_blkcnt got size=%0d want 0,1,2", bcs.size());
    end
    nerr = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < FB; i++)
        if (b * FB + i >= bits.size() ||
            bits[b * FB + i] !== spec_seq[i]) nerr++;
    total++;
    if (nerr != 0) begin
      bad++;
      $display("FAIL three_bits got %0d bad bits want 0", nerr);
    end
  endtask

  task automatic test_stall();
    int nerr;
    do_reset();
    for (int b = 0; b < 3; b++) pw[b] = FB'($urandom);
    record_pass(1, 5, -1);
    total++;
    if (stall_rdy_bad != 0 || stall_en != 0) begin
      bad++;
      $display("FAIL stall_idle got rdy_low=%0d en=%0d want 0 0",
               stall_rdy_bad, stall_en);
    end
    total++;
    if (timeout || ch_t.size() != 2 || hs[1] - hs[0] != FB + 2 + 5) begin
      bad++;
      $display("FAIL stall_timing got ch=%0d gap=%0d want 2 %0d",
               ch_t.size(), hs[1] - hs[0], FB + 7);
    end
    nerr = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < FB; i++)
        if (b * FB + i >= bits.size() ||
            bits[b * FB + i] !== pw[b][i]) nerr++;
    total++;
    if (nerr != 0 || bits.size() != 3 * FB) begin
      bad++;
      $display("FAIL stall_bits got %0d bad of %0d want 0 of %0d",
               nerr, bits.size(), 3 * FB);
    end
  endtask

  task automatic test_restart();
    bit first [$];
    int nerr;
    do_reset();
    for (int b = 0; b < 3; b++) pw[b] = FB'($urandom);
    record_pass(-1, 0, -1);
    first = bits;
    record_pass(-1, 0, 10);
    total++;
    if (r_done0 != 0 || r_bc0 != 0 || r_rdy0 != 1) begin
      bad++;
      $display("FAIL restart_entry got done=%0d bc=%0d rdy=%0d want 0 0 1",
               r_done0, r_bc0, r_rdy0);
    end
    nerr = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < FB; i++)
        if (b * FB + i >= bits.size() ||
            bits[b * FB + i] !== pw[b][i]) nerr++;
    total++;
    if (nerr != 0 || bits != first) begin
      bad++;
      $display("FAIL restart_bits got %0d bad, same=%0d want 0 1",
               nerr, bits == first);
    end
    total++;
    if (timeout || ch_t.size() != 2 || done_t != hs[2] + FB) begin
      bad++;
      $display("FAIL restart_poke got ch=%0d done=%0d want 2 %0d",
               ch_t.size(), done_t, hs[2] + FB);
    end
  endtask

  task automatic test_reset_mid();
    int e, n, seen, nerr;
    do_reset();
    for (int b = 0; b < 3; b++) pw[b] = FB'($urandom);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    e = 0;
    n = 0;
    while (e < FB + 10 && n < 200) begin
      if (en3) e++;
      if (e < FB + 10) begin
        if3.WORD_VALID = 1'b1;
        if3.WORD_DATA = pw[0];
        step();
        n++;
      end
    end
    total++;
    if (e != FB + 10 || bc3 !== 7'd1) begin
      bad++;
      $display("FAIL midrst_reach got bits=%0d bc=%0d want %0d 1",
               e, bc3, FB + 10);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    if3.WORD_VALID = 1'b0;
    total++;
    if ({din3, en3, ch3, done3, busy3, if3.WORD_READY, bc3} !== '0) begin
      bad++;
      $display("FAIL midrst_out got=%b want=0",
               {din3, en3, ch3, done3, busy3, if3.WORD_READY, bc3});
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      seen += int'(ch3) + int'(done3) + int'(busy3) + int'(if3.WORD_READY);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrst_quiet got=%0d want=0", seen);
    end
    record_pass(-1, 0, -1);
    nerr = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < FB; i++)
        if (b * FB + i >= bits.size() ||
            bits[b * FB + i] !== pw[b][i]) nerr++;
    total++;
    if (timeout || nerr != 0 || bcs.size() != 3 || bcs[0] != 0) begin
      bad++;
      $display("FAIL midrst_reload got bad=%0d blks=%0d want 0 3",
               nerr, bcs.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    if1.WORD_VALID = 1'b0;
    if3.WORD_VALID = 1'b0;
    if1.WORD_DATA = '0;
    if3.WORD_DATA = '0;
    test_reset();
    test_single();
    test_three_blocks();
    test_stall();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
